// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle turn sequencer (pbs_turn_ctrl)
// and its settle counter.
package pbs_pkg;

    typedef enum logic [3:0] {
        IDLE,
        P_SEL,
        P_HIT,
        P_WAIT,
        P_CHK,
        A_SEL,
        A_HIT,
        A_WAIT,
        A_CHK,
        DONE
    } state_t;

    localparam logic [1:0] W_NONE   = 2'b00;
    localparam logic [1:0] W_PLAYER = 2'b01;
    localparam logic [1:0] W_AI     = 2'b10;
    localparam logic [1:0] W_DRAW   = 2'b11;

    localparam logic ACTR_PLAYER = 1'b0;
    localparam logic ACTR_AI     = 1'b1;
    localparam logic TGT_PLAYER  = 1'b0;
    localparam logic TGT_AI      = 1'b1;

    localparam logic [4:0] HP_FULL = 5'b01111;

    localparam int CNT_W = 4;

endpackage

// File: rtl/pbs_settle_cnt.sv
// Loadable down-counter that times the datapath settle window after actr
// changes. zero flags the cycle in which the running decrement reaches 0.
module pbs_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count of 1 (or an empty load) means this cycle closes the window.
    assign zero = (cnt <= W'(1));

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Battle turn sequencer: accepts a player move, then runs player attack,
// faint check, AI attack, faint check. Accuracy gating: PBS_ACCU_CHECK_EN.
module pbs_turn_ctrl
    import pbs_pkg::*;
#(
    parameter int SETTLE    = 2,
    parameter int HP_W      = 5,
    parameter int MAX_TURNS = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            move_valid,
    input  logic [1:0]      move_in,
    output logic            move_ready,
    output logic [1:0]      p_move,
    output logic            actr,
    output logic            target,
    output logic            app_dmg,
    output logic            stop,
    input  logic [HP_W-1:0] p_hp,
    input  logic [HP_W-1:0] AI_hp,
    input  logic [HP_W-1:0] accu,
    input  logic [3:0]      rng_acc,
    output logic [4:0]      turn_cnt,
    output logic            game_over,
    output logic [1:0]      winner,
    output logic            missed,
    output state_t          dbg_state
);

    // Handshake: a move transfers on the rising clk edge where move_valid
    // and move_ready are both 1; move_ready is high only in IDLE.

    state_t     state, state_n;
    logic [1:0] p_move_n;
    logic       actr_n, target_n;
    logic [4:0] turn_cnt_n;
    logic       game_over_n;
    logic [1:0] winner_n;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       hit;

`ifdef PBS_ACCU_CHECK_EN
    assign hit = (accu >= HP_W'({1'b0, rng_acc}));
`else
    logic unused_acc;
    assign hit        = 1'b1;
    assign unused_acc = ^{accu, rng_acc};
`endif

    pbs_settle_cnt #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            p_move    <= 2'b00;
            actr      <= ACTR_PLAYER;
            target    <= TGT_PLAYER;
            turn_cnt  <= 5'd0;
            game_over <= 1'b0;
            winner    <= W_NONE;
        end else begin
            state     <= state_n;
            p_move    <= p_move_n;
            actr      <= actr_n;
            target    <= target_n;
            turn_cnt  <= turn_cnt_n;
            game_over <= game_over_n;
            winner    <= winner_n;
        end
    end

    always_comb begin
        state_n     = state;
        p_move_n    = p_move;
        actr_n      = actr;
        target_n    = target;
        turn_cnt_n  = turn_cnt;
        game_over_n = game_over;
        winner_n    = winner;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        move_ready  = 1'b0;
        app_dmg     = 1'b0;
        missed      = 1'b0;
        stop        = 1'b0;

        case (state)
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    p_move_n = move_in;
                    actr_n   = ACTR_PLAYER;
                    cnt_load = 1'b1;
                    state_n  = P_SEL;
                end
            end
            P_SEL: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    target_n = TGT_AI;
                    state_n  = P_HIT;
                end
            end
            P_HIT: begin
                app_dmg = hit;
                missed  = ~hit;
                state_n = P_WAIT;
            end
            P_WAIT: state_n = P_CHK;
            P_CHK: begin
                if (AI_hp == '0) begin
                    winner_n    = W_PLAYER;
                    game_over_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    actr_n   = ACTR_AI;
                    cnt_load = 1'b1;
                    state_n  = A_SEL;
                end
            end
            // stop stays high for the whole window so the AI move is frozen.
            A_SEL: begin
                stop    = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    target_n = TGT_PLAYER;
                    state_n  = A_HIT;
                end
            end
            A_HIT: begin
                app_dmg = hit;
                missed  = ~hit;
                state_n = A_WAIT;
            end
            A_WAIT: state_n = A_CHK;
            A_CHK: begin
                if (p_hp == '0) begin
                    winner_n    = W_AI;
                    game_over_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    if (turn_cnt != 5'(MAX_TURNS)) begin
                        turn_cnt_n = turn_cnt + 5'd1;
                    end
                    if (({1'b0, turn_cnt} + 6'd1) == 6'(MAX_TURNS)) begin
                        winner_n    = W_DRAW;
                        game_over_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Self-checking bench for pbs_turn_ctrl: random turns against a timeline and
// outcome model derived from the turn rules (SETTLE=2, MAX_TURNS=31).
module tb_pbs_turn_ctrl;
    import pbs_pkg::*;

    localparam int S    = 2;
    localparam int MAXT = 31;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       move_valid = 1'b0;
    logic [1:0] move_in    = 2'b00;
    logic       move_ready;
    logic [1:0] p_move;
    logic       actr, target, app_dmg, stop;
    logic [4:0] p_hp  = HP_FULL;
    logic [4:0] ai_hp = HP_FULL;
    logic [4:0] accu  = 5'd0;
    logic [3:0] rng_acc = 4'd0;
    logic [4:0] turn_cnt;
    logic       game_over;
    logic [1:0] winner;
    logic       missed;
    state_t     dbg_state;

    pbs_turn_ctrl #(.SETTLE(S), .HP_W(5), .MAX_TURNS(MAXT)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .move_in    (move_in),
        .move_ready (move_ready),
        .p_move     (p_move),
        .actr       (actr),
        .target     (target),
        .app_dmg    (app_dmg),
        .stop       (stop),
        .p_hp       (p_hp),
        .AI_hp      (ai_hp),
        .accu       (accu),
        .rng_acc    (rng_acc),
        .turn_cnt   (turn_cnt),
        .game_over  (game_over),
        .winner     (winner),
        .missed     (missed),
        .dbg_state  (dbg_state)
    );

    // scoreboard and reference model
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    int         mdl_turns  = 0;
    bit         mdl_over   = 1'b0;
    logic [1:0] mdl_winner = W_NONE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_move_ready", move_ready, 1);
        check("rst_p_move", p_move, 0);
        check("rst_actr", actr, 0);
        check("rst_target", target, 0);
        check("rst_app_dmg", app_dmg, 0);
        check("rst_stop", stop, 0);
        check("rst_turn_cnt", turn_cnt, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        check("rst_missed", missed, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        move_valid = 1'b0;
        p_hp       = HP_FULL;
        ai_hp      = HP_FULL;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst        = 1'b1;
        mdl_turns  = 0;
        mdl_over   = 1'b0;
        mdl_winner = W_NONE;
        exp_q.delete();
    endtask

    // One turn, starting at a negedge in IDLE. outcome: 0 nobody faints,
    // 1 AI faints after the player hit, 2 player faints after the AI hit.
    // rst_k > 0 pulls reset in that cycle after the accept.
    task automatic run_turn(input logic [1:0] mv, input int outcome, input bit chain,
                            input logic [1:0] next_mv, input int rst_k,
                            input int accu_v, input int rng_v);
        int         p_hit_k, a_hit_k, end_k;
        bit         hit, exp_app, exp_miss, a_live;
        logic [1:0] q_mv;
        p_hit_k = S + 1;
        a_hit_k = 2 * S + 4;
        end_k   = 2 * S + 7;
        accu    = 5'(accu_v);
        rng_acc = 4'(rng_v);
`ifdef PBS_ACCU_CHECK_EN
        hit = (accu_v >= rng_v);
`else
        hit = 1'b1;
`endif
        check("ready_before_accept", move_ready, 1);
        move_valid = 1'b1;
        move_in    = mv;
        exp_q.push_back(mv);
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        move_in    = 2'($urandom_range(0, 3));
        for (int k = 1; k <= end_k; k++) begin
            if (outcome == 1 && k == S + 4) begin
                mdl_over   = 1'b1;
                mdl_winner = W_PLAYER;
            end
            if (outcome != 1 && k == end_k) begin
                if (outcome == 2) begin
                    mdl_over   = 1'b1;
                    mdl_winner = W_AI;
                end else begin
                    mdl_turns++;
                    if (mdl_turns == MAXT) begin
                        mdl_over   = 1'b1;
                        mdl_winner = W_DRAW;
                    end
                end
            end
            a_live   = (outcome != 1);
            exp_app  = hit && ((k == p_hit_k) || (k == a_hit_k && a_live));
`ifdef PBS_ACCU_CHECK_EN
            exp_miss = !hit && ((k == p_hit_k) || (k == a_hit_k && a_live));
`else
            exp_miss = 1'b0;
`endif
            if (k == 1) begin
                q_mv = exp_q.pop_front();
                check("p_move_latched", p_move, q_mv);
            end
            check("app_dmg", app_dmg, exp_app);
            check("missed", missed, exp_miss);
            check("stop", stop, (a_live && k >= S + 4 && k <= 2 * S + 3));
            check("move_ready", move_ready, (k == end_k && !mdl_over));
            check("game_over", game_over, mdl_over);
            check("winner", winner, mdl_winner);
            check("turn_cnt", turn_cnt, mdl_turns);
            if (k == p_hit_k) begin
                check("target_p_hit", target, TGT_AI);
                check("actr_p_hit", actr, ACTR_PLAYER);
            end
            if (k == a_hit_k && a_live) begin
                check("target_a_hit", target, TGT_PLAYER);
                check("actr_a_hit", actr, ACTR_AI);
            end
            if (k == rst_k) begin
                do_reset();
                return;
            end
            if (k == S + 2 && outcome == 1) ai_hp = 5'd0;
            if (k == 2 * S + 5 && outcome == 2) p_hp = 5'd0;
            if (chain && k == 2 * S + 6) begin
                move_valid = 1'b1;
                move_in    = next_mv;
            end
            if (k < end_k) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("ready_idle", move_ready, !mdl_over);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // n turns; only the last one may end the game via last_outcome.
    task automatic play(input int n, input int last_outcome);
        logic [1:0] cur, nxt;
        bit         ch;
        int         oc;
        cur = 2'($urandom_range(0, 3));
        for (int i = 0; i < n; i++) begin
            nxt = 2'($urandom_range(0, 3));
            oc  = (i == n - 1) ? last_outcome : 0;
            ch  = (i < n - 1) && ($urandom_range(0, 1) == 1);
            run_turn(cur, oc, ch, nxt, 0, $urandom_range(0, 20), $urandom_range(0, 15));
            if (!ch && i < n - 1) idle_cycles($urandom_range(0, 3));
            cur = nxt;
        end
    endtask

    // A finished game must ignore further moves.
    task automatic post_over();
        move_valid = 1'b1;
        move_in    = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("over_ready", move_ready, 0);
            check("over_game_over", game_over, 1);
            check("over_winner", winner, mdl_winner);
            check("over_app_dmg", app_dmg, 0);
            check("over_turn_cnt", turn_cnt, mdl_turns);
        end
        move_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // first move 2'b10: miss with the accuracy gate, then a hit
        run_turn(2'b10, 0, 1'b0, 2'b00, 0, 5, 9);
        idle_cycles(1);
        run_turn(2'($urandom_range(0, 3)), 0, 1'b0, 2'b00, 0, 5, 3);
        play(4, 0);

        // reset in the first A_SEL cycle abandons the turn
        run_turn(2'($urandom_range(0, 3)), 0, 1'b0, 2'b00, S + 4,
                 $urandom_range(0, 20), $urandom_range(0, 15));
        idle_cycles(2);

        // AI faints: player wins, AI attack never issued
        play(3, 1);
        post_over();
        do_reset();

        // player faints: AI wins, turn count not advanced
        play(4, 2);
        post_over();
        do_reset();

        // nobody faints for MAX_TURNS turns: draw
        play(MAXT, 0);
        post_over();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pbs_turn_ctrl.md
Name: pbs_turn_ctrl

Overview:
- Battle turn sequencer for the Pokémon-battle datapath (pbs_dp).
- Accepts a player move through a valid/ready handshake, then runs one full turn: player attack on AI, faint check, AI attack on player, faint check.
- Drives the datapath controls actr, target, app_dmg and stop; reads back p_hp, AI_hp and accu.
- Reports winner and game-over status to the display and top level.

Parameters:
- SETTLE, 2, cycles held in a SEL state after actr changes before dmg is stable (actr register plus dmg register).
- HP_W, 5, HP/dmg/accu width.
- MAX_TURNS, 31, turn limit; reaching it ends the game as a draw.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- move_valid  in  1  player move offered
- move_in  in  2  player move code
- move_ready  out  1  controller can accept a move
- p_move  out  2  latched player move, to datapath
- actr  out  1  0 = player acts, 1 = AI acts
- target  out  1  0 = player takes damage, 1 = AI takes damage
- app_dmg  out  1  one-cycle damage-apply strobe
- stop  out  1  freezes the RNGs while the AI move is sampled
- p_hp  in  HP_W  player HP from datapath
- AI_hp  in  HP_W  AI HP from datapath
- accu  in  HP_W  current move accuracy
- rng_acc  in  4  accuracy random value
- turn_cnt  out  5  completed turns
- game_over  out  1  sticky end flag
- winner  out  2  00 none, 01 player, 10 AI, 11 draw
- missed  out  1  pulses one cycle when an attack misses (feature only)

Behaviour:
- Reset is synchronous: on rst=0 at a clk edge, state=IDLE and all outputs go to 0, except move_ready=1. A reset mid-turn abandons the turn without issuing app_dmg.
- States: IDLE, P_SEL, P_HIT, P_WAIT, P_CHK, A_SEL, A_HIT, A_WAIT, A_CHK, DONE.
- IDLE:
  - move_ready=1.
  - On move_valid&&move_ready: latch move_in into p_move, set actr=0, load settle counter with SETTLE, go to P_SEL.
  - move_valid while not in IDLE is ignored; move_ready=0 outside IDLE.
- P_SEL: actr=0. Decrement the counter each cycle; at 0 go to P_HIT.
- P_HIT: target=1, app_dmg=1 for exactly one cycle, then P_WAIT.
- P_WAIT: one cycle for the HP register to update, then P_CHK.
- P_CHK:
  - AI_hp==0: winner=01, go to DONE.
  - Otherwise: actr=1, stop=1, reload the counter, go to A_SEL.
- A_SEL:
  - actr=1, stop held at 1 so the AI move stays stable.
  - At counter 0: stop=0, go to A_HIT.
- A_HIT: target=0, app_dmg=1 for one cycle, then A_WAIT.
- A_WAIT: one cycle, then A_CHK.
- A_CHK:
  - p_hp==0: winner=10, go to DONE.
  - Otherwise: increment turn_cnt.
  - If turn_cnt+1==MAX_TURNS: winner=11, go to DONE.
  - Otherwise: return to IDLE.
- DONE: game_over=1, move_ready=0, held until reset.
- target and actr are registered and hold their last value outside the states that set them.
- turn_cnt saturates at MAX_TURNS and never wraps.
- A move_valid that arrives in the same cycle as the A_CHK→IDLE transition is not accepted; it is accepted on the next cycle.
- Latency from the accepting handshake to the first app_dmg is SETTLE+1 cycles.
- A full non-terminal turn takes 2*SETTLE+7 cycles from the accept to the return to IDLE.

Optional Feature:
- Macro: PBS_ACCU_CHECK_EN.
- When defined:
  - In P_HIT and A_HIT, app_dmg is asserted only if accu >= {1'b0,rng_acc}.
  - On a miss, app_dmg=0 and missed=1 for that cycle; the sequence continues unchanged (WAIT, then CHK).
- When undefined: every attack hits; missed is tied to 0 and rng_acc is unused.

Decomposition:
- Package pbs_pkg holds:
  - the state enum;
  - winner codes W_NONE, W_PLAYER, W_AI, W_DRAW;
  - the ACTR_PLAYER/ACTR_AI and TGT_PLAYER/TGT_AI constants;
  - the HP_FULL=5'b01111 constant.
- One sub-module, pbs_settle_cnt: a loadable down-counter with a zero flag, reused by P_SEL and A_SEL.

Test Plan:
- Reset then move_valid=1, move_in=10 → move_ready drops next cycle; p_move=10; app_dmg with target=1 exactly 3 cycles after the accept (SETTLE=2).
- AI_hp forced to 0 in P_WAIT → P_CHK sets winner=01 and game_over=1; the AI attack is never issued (no app_dmg with target=0).
- p_hp forced to 0 after the AI hit → winner=10, game_over=1, turn_cnt unchanged.
- Neither side faints for 31 turns → winner=11 after the 31st turn; turn_cnt=31; move_ready stays 0.
- rst=0 asserted during A_SEL → next cycle state is IDLE, all outputs 0, move_ready=1, no app_dmg pulse.
- With PBS_ACCU_CHECK_EN, accu=5, rng_acc=9 → missed=1 and app_dmg=0 in P_HIT; with rng_acc=3 → app_dmg=1.
